hazard_ctrl_pipe: RTL and testbench
===================================

Name: hazard_ctrl_pipe

Overview:
- Downstream consumer of the ID-stage control bundle produced by the opcode decoder.
- Carries the bundle and the destination register through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use hazards and inserts bubbles.
- Flushes on taken branches and jumps, and generates EX-stage forwarding selects for the 5-stage MIPS datapath.

Parameters:
- REG_ADDR_W, 5, register-index width.
- CTRL_W, 16, packed control bundle width.
- LINK_REG, 31, destination register for link writes (MemtoReg==2'b10).

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- ID_Ctrl  in  16  decoder bundle: {RegDst, ALUSrc, MemtoReg[1:0], RegWrite, MemRead, MemWrite, Branch, Jump[1:0], ALUOp[5:0]}, MSB first.
- ID_Rs, ID_Rt, ID_Rd  in  5 each  register fields of the ID instruction.
- EX_BranchTaken  in  1  branch comparison result; qualified by EX_Ctrl.Branch with EX_Ctrl.Jump==0.
- EX_Ctrl, MEM_Ctrl, WB_Ctrl  out  16 each  registered bundles per stage.
- EX_Rs, EX_Rt  out  5 each  registered source indices.
- EX_WriteReg, MEM_WriteReg, WB_WriteReg  out  5 each  registered destination per stage.
- PCWrite  out  1  PC update enable.
- IFIDWrite  out  1  IF/ID register enable.
- IFIDFlush  out  1  zero the IF/ID register next edge.
- ForwardA, ForwardB  out  2 each  EX operand select: 00 = regfile, 10 = MEM result, 01 = WB result.

Behaviour:
- Reset (sync, Reset high at edge):
  - All stage bundles, indices and WriteRegs load 0.
  - Combinational outputs while Reset high: PCWrite=1, IFIDWrite=1, IFIDFlush=0, ForwardA/B=00.
- Destination select at ID:
  - MemtoReg==2'b10 → LINK_REG.
  - else RegDst → ID_Rd.
  - else ID_Rt.
- Latency: one cycle per stage. ID→EX, EX→MEM and MEM→WB each shift every edge; MEM/WB never stall.
- Load-use stall:
  - Condition: EX_Ctrl.MemRead && EX_WriteReg!=0 && (EX_WriteReg==ID_Rs || EX_WriteReg==ID_Rt).
  - Effect: PCWrite=0, IFIDWrite=0; ID/EX loads bubble (all-zero bundle, WriteReg=0, Rs/Rt=0).
  - Duration: exactly one cycle, because the bubble clears EX_Ctrl.MemRead.
- Taken branch (EX_Ctrl.Branch && EX_Ctrl.Jump==0 && EX_BranchTaken):
  - IFIDFlush=1 and ID/EX loads bubble; PCWrite=1, IFIDWrite=1.
  - Overrides a simultaneous load-use stall.
- Jump in ID (ID_Ctrl.Jump==2'b01, no stall, no taken branch):
  - IFIDFlush=1.
  - The jump/jal bundle itself advances to EX (jal writes LINK_REG).
- Priority: Reset > taken branch > load-use stall > jump > normal.
- Forwarding (combinational, evaluated per source X ∈ {EX_Rs, EX_Rt}):
  - 10 if MEM_Ctrl.RegWrite && MEM_WriteReg!=0 && MEM_WriteReg==X.
  - else 01 if WB_Ctrl.RegWrite && WB_WriteReg!=0 && WB_WriteReg==X.
  - else 00.
  - MEM beats WB when both match. Register 0 never forwards.
- Reset asserted mid-stall or mid-flush: all stages become bubbles; no stall or flush carries over.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - Adds outputs StallCount[31:0] and FlushCount[31:0], both synchronously reset to 0.
  - StallCount +1 per cycle with a load-use stall that was not overridden.
  - FlushCount +1 per cycle with IFIDFlush=1.
  - Both wrap at 2^32-1 → 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package pipe_ctrl_pkg:
  - CTRL_W.
  - Bundle bit-position constants (CTRL_REGDST … CTRL_ALUOP_LSB).
  - FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - LINK_REG.
  - BUBBLE constant (16'h0000).
- One sub-module: fwd_unit. Purely combinational forwarding compare, instantiated once with both EX sources; reused by a future branch-in-ID unit.

Test Plan:
- Reset: hold Reset 2 cycles with nonzero ID_Ctrl → all stage bundles 0, PCWrite=1, IFIDWrite=1, Forward=00. After release, ID_Ctrl appears on EX_Ctrl 1 cycle later, MEM 2 cycles later, WB 3 cycles later.
- Load-use: lw into $8, then next ID has Rs=8 → one cycle with PCWrite=0, IFIDWrite=0, EX_Ctrl=0. Next cycle ForwardA=01 (WB). With Rs=0 as destination → no stall.
- Forwarding: add $5 followed by sub using Rs=5, Rt=5 → ForwardA=ForwardB=10. Same register written in both MEM and WB → 10. MEM writes $0 → 00.
- Taken branch: beq in EX with EX_BranchTaken=1 while a load-use condition is also present → IFIDFlush=1, PCWrite=1, EX_Ctrl next = 0. EX_BranchTaken=0 → no flush.
- jal: ID_Ctrl with Jump=01, MemtoReg=10 → IFIDFlush=1 same cycle; EX_WriteReg=31 next cycle; WB_WriteReg=31 three cycles later.
- HAZARD_PERF_CNT_EN: 3 stalls + 2 flushes → StallCount=3, FlushCount=2. Preload 32'hFFFFFFFF then one stall → StallCount=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the MIPS pipeline control path: control-bundle bit
// positions, forwarding select encodings, link register index and bubble.
package pipe_ctrl_pkg;

  localparam int CTRL_W     = 16;
  localparam int REG_ADDR_W = 5;
  localparam int LINK_REG   = 31;

  // Bit positions within the decoder bundle, MSB first:
  // {RegDst, ALUSrc, MemtoReg[1:0], RegWrite, MemRead, MemWrite, Branch,
  //  Jump[1:0], ALUOp[5:0]}
  localparam int CTRL_REGDST       = 15;
  localparam int CTRL_ALUSRC       = 14;
  localparam int CTRL_MEMTOREG_MSB = 13;
  localparam int CTRL_MEMTOREG_LSB = 12;
  localparam int CTRL_REGWRITE     = 11;
  localparam int CTRL_MEMREAD      = 10;
  localparam int CTRL_MEMWRITE     = 9;
  localparam int CTRL_BRANCH       = 8;
  localparam int CTRL_JUMP_MSB     = 7;
  localparam int CTRL_JUMP_LSB     = 6;
  localparam int CTRL_ALUOP_MSB    = 5;
  localparam int CTRL_ALUOP_LSB    = 0;

  // EX operand source selects
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // MemtoReg encoding that marks a link write (jal)
  localparam logic [1:0] MEMTOREG_LINK = 2'b10;
  // Jump encoding resolved in ID
  localparam logic [1:0] JUMP_DIRECT   = 2'b01;

  // All-zero bundle: no register, memory or PC side effects
  localparam logic [CTRL_W-1:0] BUBBLE = 16'h0000;

endpackage

// File: rtl/hazard_ctrl_pipe_fwd.sv
// fwd_unit: purely combinational forwarding compare for two source indices.
// MEM result takes priority over WB; register 0 never forwards.
module fwd_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  mem_regwrite,
  input  logic [REG_ADDR_W-1:0] mem_write_reg,
  input  logic                  wb_regwrite,
  input  logic [REG_ADDR_W-1:0] wb_write_reg,
  input  logic [REG_ADDR_W-1:0] src_a,
  input  logic [REG_ADDR_W-1:0] src_b,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b
);

  logic [1:0][REG_ADDR_W-1:0] src;
  logic [1:0][1:0]            sel;

  assign src[0] = src_a;
  assign src[1] = src_b;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      // Per-source priority compare: MEM first, then WB, else register file
      always_comb begin
        sel[gi] = FWD_REG;
        if (mem_regwrite && (mem_write_reg != '0) && (mem_write_reg == src[gi])) begin
          sel[gi] = FWD_MEM;
        end else if (wb_regwrite && (wb_write_reg != '0) && (wb_write_reg == src[gi])) begin
          sel[gi] = FWD_WB;
        end
      end
    end
  endgenerate

  assign fwd_a = sel[0];
  assign fwd_b = sel[1];

endmodule

// File: rtl/hazard_ctrl_pipe.sv
// hazard_ctrl_pipe: carries the ID control bundle and destination register
// through ID/EX, EX/MEM and MEM/WB; detects load-use hazards, flushes on taken
// branches and ID jumps, and drives EX forwarding selects.
// Optional macro HAZARD_PERF_CNT_EN adds StallCount/FlushCount outputs.
module hazard_ctrl_pipe #(
  parameter int REG_ADDR_W = pipe_ctrl_pkg::REG_ADDR_W,
  parameter int CTRL_W     = pipe_ctrl_pkg::CTRL_W,
  parameter int LINK_REG   = pipe_ctrl_pkg::LINK_REG
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [CTRL_W-1:0]     ID_Ctrl,
  input  logic [REG_ADDR_W-1:0] ID_Rs,
  input  logic [REG_ADDR_W-1:0] ID_Rt,
  input  logic [REG_ADDR_W-1:0] ID_Rd,
  input  logic                  EX_BranchTaken,
  output logic [CTRL_W-1:0]     EX_Ctrl,
  output logic [CTRL_W-1:0]     MEM_Ctrl,
  output logic [CTRL_W-1:0]     WB_Ctrl,
  output logic [REG_ADDR_W-1:0] EX_Rs,
  output logic [REG_ADDR_W-1:0] EX_Rt,
  output logic [REG_ADDR_W-1:0] EX_WriteReg,
  output logic [REG_ADDR_W-1:0] MEM_WriteReg,
  output logic [REG_ADDR_W-1:0] WB_WriteReg,
  output logic                  PCWrite,
  output logic                  IFIDWrite,
  output logic                  IFIDFlush,
  output logic [1:0]            ForwardA,
  output logic [1:0]            ForwardB
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           StallCount,
  output logic [31:0]           FlushCount
`endif
);

  import pipe_ctrl_pkg::*;

  logic [CTRL_W-1:0]     ex_ctrl_q, ex_ctrl_d;
  logic [CTRL_W-1:0]     mem_ctrl_q, mem_ctrl_d;
  logic [CTRL_W-1:0]     wb_ctrl_q, wb_ctrl_d;
  logic [REG_ADDR_W-1:0] ex_rs_q, ex_rs_d;
  logic [REG_ADDR_W-1:0] ex_rt_q, ex_rt_d;
  logic [REG_ADDR_W-1:0] ex_wr_q, ex_wr_d;
  logic [REG_ADDR_W-1:0] mem_wr_q, mem_wr_d;
  logic [REG_ADDR_W-1:0] wb_wr_q, wb_wr_d;

  logic [REG_ADDR_W-1:0] id_write_reg;
  logic                  load_use;
  logic                  branch_taken;
  logic                  jump_id;
  logic                  id_bubble;
  logic                  stall_active;
  logic                  pc_write;
  logic                  ifid_write;
  logic                  ifid_flush;
  logic [1:0]            fwd_a_raw;
  logic [1:0]            fwd_b_raw;

  // Destination register chosen at ID: link register, rd, or rt
  always_comb begin
    id_write_reg = ID_Rt;
    if (ID_Ctrl[CTRL_MEMTOREG_MSB:CTRL_MEMTOREG_LSB] == MEMTOREG_LINK) begin
      id_write_reg = REG_ADDR_W'(LINK_REG);
    end else if (ID_Ctrl[CTRL_REGDST]) begin
      id_write_reg = ID_Rd;
    end
  end

  assign load_use     = ex_ctrl_q[CTRL_MEMREAD] && (ex_wr_q != '0) &&
                        ((ex_wr_q == ID_Rs) || (ex_wr_q == ID_Rt));
  assign branch_taken = ex_ctrl_q[CTRL_BRANCH] &&
                        (ex_ctrl_q[CTRL_JUMP_MSB:CTRL_JUMP_LSB] == 2'b00) &&
                        EX_BranchTaken;
  assign jump_id      = (ID_Ctrl[CTRL_JUMP_MSB:CTRL_JUMP_LSB] == JUMP_DIRECT);

  // Hazard priority: reset > taken branch > load-use stall > ID jump > normal
  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    id_bubble    = 1'b0;
    stall_active = 1'b0;
    if (!Reset) begin
      if (branch_taken) begin
        ifid_flush = 1'b1;
        id_bubble  = 1'b1;
      end else if (load_use) begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        id_bubble    = 1'b1;
        stall_active = 1'b1;
      end else if (jump_id) begin
        ifid_flush = 1'b1;
      end
    end
  end

  // Next-state for the three pipeline registers; MEM/WB always shift
  always_comb begin
    ex_ctrl_d  = ID_Ctrl;
    ex_rs_d    = ID_Rs;
    ex_rt_d    = ID_Rt;
    ex_wr_d    = id_write_reg;
    mem_ctrl_d = ex_ctrl_q;
    mem_wr_d   = ex_wr_q;
    wb_ctrl_d  = mem_ctrl_q;
    wb_wr_d    = mem_wr_q;
    if (Reset || id_bubble) begin
      ex_ctrl_d = BUBBLE;
      ex_rs_d   = '0;
      ex_rt_d   = '0;
      ex_wr_d   = '0;
    end
    if (Reset) begin
      mem_ctrl_d = BUBBLE;
      mem_wr_d   = '0;
      wb_ctrl_d  = BUBBLE;
      wb_wr_d    = '0;
    end
  end

  // Pipeline state registers
  always_ff @(posedge Clk) begin
    ex_ctrl_q  <= ex_ctrl_d;
    ex_rs_q    <= ex_rs_d;
    ex_rt_q    <= ex_rt_d;
    ex_wr_q    <= ex_wr_d;
    mem_ctrl_q <= mem_ctrl_d;
    mem_wr_q   <= mem_wr_d;
    wb_ctrl_q  <= wb_ctrl_d;
    wb_wr_q    <= wb_wr_d;
  end

  fwd_unit #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd (
    .mem_regwrite  (mem_ctrl_q[CTRL_REGWRITE]),
    .mem_write_reg (mem_wr_q),
    .wb_regwrite   (wb_ctrl_q[CTRL_REGWRITE]),
    .wb_write_reg  (wb_wr_q),
    .src_a         (ex_rs_q),
    .src_b         (ex_rt_q),
    .fwd_a         (fwd_a_raw),
    .fwd_b         (fwd_b_raw)
  );

  assign EX_Ctrl      = ex_ctrl_q;
  assign MEM_Ctrl     = mem_ctrl_q;
  assign WB_Ctrl      = wb_ctrl_q;
  assign EX_Rs        = ex_rs_q;
  assign EX_Rt        = ex_rt_q;
  assign EX_WriteReg  = ex_wr_q;
  assign MEM_WriteReg = mem_wr_q;
  assign WB_WriteReg  = wb_wr_q;
  assign PCWrite      = pc_write;
  assign IFIDWrite    = ifid_write;
  assign IFIDFlush    = ifid_flush;
  assign ForwardA     = Reset ? FWD_REG : fwd_a_raw;
  assign ForwardB     = Reset ? FWD_REG : fwd_b_raw;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Event counters; plain increment wraps naturally at 2^32
  always_comb begin
    stall_cnt_d = stall_cnt_q + (stall_active ? 32'd1 : 32'd0);
    flush_cnt_d = flush_cnt_q + (ifid_flush ? 32'd1 : 32'd0);
  end

  // Counter registers, cleared by reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Testbench for hazard_ctrl_pipe: directed per-cycle vectors with hand-computed
// expectations pushed to a scoreboard queue; a negedge monitor pops and checks.
module tb_hazard_ctrl_pipe;

  localparam logic [15:0] NOP  = 16'h0000;
  localparam logic [15:0] ADD  = 16'h8820;
  localparam logic [15:0] SUB  = 16'h8822;
  localparam logic [15:0] LW   = 16'h5C23;
  localparam logic [15:0] LWBR = 16'h5D23; // load bundle that also branches
  localparam logic [15:0] BEQ  = 16'h0104;
  localparam logic [15:0] JAL  = 16'h2843;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] id_ctrl;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        bt;
  logic [15:0] ex_ctrl, mem_ctrl, wb_ctrl;
  logic [4:0]  ex_rs, ex_rt, ex_wr, mem_wr, wb_wr;
  logic        pcw, ifw, flush;
  logic [1:0]  fa, fb;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int vec_idx = 0;

  typedef struct {
    int          idx;
    logic        pcw, ifw, fl;
    logic [1:0]  fa, fb;
    logic [15:0] exc, wbc;
    logic [4:0]  exwr, memwr, wbwr;
    logic        chk_cnt;
    logic [31:0] sc, fc;
  } exp_t;

  exp_t sb[$];

  logic        cnt_chk_next = 1'b0;
  logic [31:0] sc_next = '0;
  logic [31:0] fc_next = '0;

  always #5 clk = ~clk;

  hazard_ctrl_pipe dut (
    .Clk            (clk),
    .Reset          (rst),
    .ID_Ctrl        (id_ctrl),
    .ID_Rs          (id_rs),
    .ID_Rt          (id_rt),
    .ID_Rd          (id_rd),
    .EX_BranchTaken (bt),
    .EX_Ctrl        (ex_ctrl),
    .MEM_Ctrl       (mem_ctrl),
    .WB_Ctrl        (wb_ctrl),
    .EX_Rs          (ex_rs),
    .EX_Rt          (ex_rt),
    .EX_WriteReg    (ex_wr),
    .MEM_WriteReg   (mem_wr),
    .WB_WriteReg    (wb_wr),
    .PCWrite        (pcw),
    .IFIDWrite      (ifw),
    .IFIDFlush      (flush),
    .ForwardA       (fa),
    .ForwardB       (fb)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .StallCount     (stall_cnt),
    .FlushCount     (flush_cnt)
`endif
  );

  task automatic cmp(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exv);
    n_cmp++;
    if (act !== exv) begin
      n_bad++;
      $display("FAIL v%0d %s: got %0h expected %0h", idx, nm, act, exv);
    end
  endtask

  // One cycle of stimulus plus its expected observable state
  task automatic vec(input logic r, input logic [15:0] c, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd, input logic b,
                     input logic e_pcw, input logic e_ifw, input logic e_fl,
                     input logic [1:0] e_fa, input logic [1:0] e_fb,
                     input logic [15:0] e_exc, input logic [4:0] e_exwr, input logic [4:0] e_memwr,
                     input logic [4:0] e_wbwr, input logic [15:0] e_wbc);
    exp_t e;
    @(posedge clk);
    #1;
    vec_idx++;
    rst = r; id_ctrl = c; id_rs = rs; id_rt = rt; id_rd = rd; bt = b;
    e.idx = vec_idx; e.pcw = e_pcw; e.ifw = e_ifw; e.fl = e_fl; e.fa = e_fa; e.fb = e_fb;
    e.exc = e_exc; e.exwr = e_exwr; e.memwr = e_memwr; e.wbwr = e_wbwr; e.wbc = e_wbc;
    e.chk_cnt = cnt_chk_next; e.sc = sc_next; e.fc = fc_next;
    cnt_chk_next = 1'b0;
    sb.push_back(e);
    $display("vec %0d: rst=%0b ctrl=%04h rs=%0d rt=%0d rd=%0d bt=%0b", vec_idx, r, c, rs, rt, rd, b);
  endtask

  // Monitor: pops one expectation per cycle and compares all outputs
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      cmp("PCWrite",      e.idx, 32'(pcw),      32'(e.pcw));
      cmp("IFIDWrite",    e.idx, 32'(ifw),      32'(e.ifw));
      cmp("IFIDFlush",    e.idx, 32'(flush),    32'(e.fl));
      cmp("ForwardA",     e.idx, 32'(fa),       32'(e.fa));
      cmp("ForwardB",     e.idx, 32'(fb),       32'(e.fb));
      cmp("EX_Ctrl",      e.idx, 32'(ex_ctrl),  32'(e.exc));
      cmp("EX_WriteReg",  e.idx, 32'(ex_wr),    32'(e.exwr));
      cmp("MEM_WriteReg", e.idx, 32'(mem_wr),   32'(e.memwr));
      cmp("WB_WriteReg",  e.idx, 32'(wb_wr),    32'(e.wbwr));
      cmp("WB_Ctrl",      e.idx, 32'(wb_ctrl),  32'(e.wbc));
`ifdef HAZARD_PERF_CNT_EN
      if (e.chk_cnt) begin
        cmp("StallCount", e.idx, stall_cnt, e.sc);
        cmp("FlushCount", e.idx, flush_cnt, e.fc);
      end
`endif
    end
  end

  initial begin
    rst = 1'b1; id_ctrl = ADD; id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3; bt = 1'b0;
    // reset held two cycles with a live bundle at ID
    vec(1, ADD, 1, 2, 3, 0,  1, 1, 0, 0, 0,  NOP, 0, 0, 0, NOP);
    // bundle latency through EX, MEM, WB
    vec(0, ADD, 1, 2, 3, 0,  1, 1, 0, 0, 0,  NOP, 0, 0, 0, NOP);
    vec(0, NOP, 0, 0, 0, 0,  1, 1, 0, 0, 0,  ADD, 3, 0, 0, NOP);
    vec(0, NOP, 0, 0, 0, 0,  1, 1, 0, 0, 0,  NOP, 0, 3, 0, NOP);
    vec(0, NOP, 0, 0, 0, 0,  1, 1, 0, 0, 0,  NOP, 0, 0, 3, ADD);
    // lw $8 then consumer of $8: one stall, then WB forwarding
    vec(0, LW,  1, 8, 0, 0,  1, 1, 0, 0, 0,  NOP, 0, 0, 0, NOP);
    vec(0, ADD, 8, 2, 9, 0,  0, 0, 0, 0, 0,  LW,  8, 0, 0, NOP);
    vec(0, ADD, 8, 2, 9, 0,  1, 1, 0, 0, 0,  NOP, 0, 8, 0, NOP);
    vec(0, NOP, 0, 0, 0, 0,  1, 1, 0, 1, 0,  ADD, 9, 0, 8, LW);
    // lw into $0: no stall, no forwarding from $0
    vec(0, LW,  1, 0, 0, 0,  1, 1, 0, 0, 0,  NOP, 0, 9, 0, NOP);
    vec(0, ADD, 0, 0, 4, 0,  1, 1, 0, 0, 0,  LW,  0, 0, 9, ADD);
    vec(0, NOP, 0, 0, 0, 0,  1, 1, 0, 0, 0,  ADD, 4, 0, 0, NOP);
    // add $5 ; sub $6,$5,$5 -> both from MEM
    vec(0, ADD, 1, 2, 5, 0,  1, 1, 0, 0, 0,  NOP, 0, 4, 0, LW);
    vec(0, SUB, 5, 5, 6, 0,  1, 1, 0, 0, 0,  ADD, 5, 0, 4, ADD);
    vec(0, ADD, 1, 2, 5, 0,  1, 1, 0, 2, 2,  SUB, 6, 5, 0, NOP);
    // $5 written in both MEM and WB -> MEM wins
    vec(0, ADD, 1, 2, 5, 0,  1, 1, 0, 0, 0,  ADD, 5, 6, 5, ADD);
    vec(0, SUB, 5, 6, 7, 0,  1, 1, 0, 0, 0,  ADD, 5, 5, 6, SUB);
    vec(0, NOP, 0, 0, 0, 0,  1, 1, 0, 2, 0,  SUB, 7, 5, 5, ADD);
    // rt from WB; then a write to $0 in MEM never forwards to a $0 source
    vec(0, ADD, 1, 7, 0, 0,  1, 1, 0, 0, 0,  NOP, 0, 7, 5, ADD);
    vec(0, ADD, 0, 7, 3, 0,  1, 1, 0, 0, 1,  ADD, 0, 0, 7, SUB);
    vec(0, NOP, 0, 0, 0, 0,  1, 1, 0, 0, 0,  ADD, 3, 0, 0, NOP);
    // taken branch overriding a simultaneous load-use
    vec(0, LWBR,1, 8, 0, 0,  1, 1, 0, 0, 0,  NOP, 0, 3, 0, ADD);
    vec(0, ADD, 8, 0, 9, 1,  1, 1, 1, 0, 0,  LWBR,8, 0, 3, ADD);
    // branch in EX not taken -> no flush
    vec(0, BEQ, 1, 2, 0, 1,  1, 1, 0, 0, 0,  NOP, 0, 8, 0, NOP);
    vec(0, NOP, 0, 0, 0, 0,  1, 1, 0, 0, 0,  BEQ, 2, 0, 8, LWBR);
    // jal: flush now, link register down the pipe
    vec(0, JAL, 0, 0, 0, 0,  1, 1, 1, 0, 0,  NOP, 0, 2, 0, NOP);
    vec(0, NOP, 0, 0, 0, 0,  1, 1, 0, 0, 0,  JAL, 31, 0, 2, BEQ);
    vec(0, NOP, 0, 0, 0, 0,  1, 1, 0, 0, 0,  NOP, 0, 31, 0, NOP);
    vec(0, NOP, 0, 0, 0, 0,  1, 1, 0, 0, 0,  NOP, 0, 0, 31, JAL);
    // one unoverridden stall and two flushes so far
    cnt_chk_next = 1'b1; sc_next = 32'd1; fc_next = 32'd2;
    vec(0, LW,  1, 8, 0, 0,  1, 1, 0, 0, 0,  NOP, 0, 0, 0, NOP);
    // reset while a stall condition is present
    vec(1, ADD, 8, 2, 9, 0,  1, 1, 0, 0, 0,  LW,  8, 0, 0, NOP);
    cnt_chk_next = 1'b1; sc_next = 32'd0; fc_next = 32'd0;
    vec(0, ADD, 8, 2, 9, 0,  1, 1, 0, 0, 0,  NOP, 0, 0, 0, NOP);
    vec(0, NOP, 0, 0, 0, 0,  1, 1, 0, 0, 0,  ADD, 9, 0, 0, NOP);

    @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
